// File: rtl/atm_fsm_controller.sv
// ATM session controller: card -> PIN (3-strike lockout) -> mode -> optional face check -> deposit/withdraw.
// Optional build macro ATM_LOCK_CLEAR_ON_EJECT_EN: card ejection releases the LOCKED state.
module atm_fsm_controller #(
    parameter logic [3:0] INIT_BALANCE = 4'd10,
    parameter logic [3:0] FACE_LIMIT   = 4'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       insert_card,
    input  logic       PIN,
    input  logic       transac_mode,
    input  logic       face_recog,
    input  logic       deposit_withdraw,
    input  logic [3:0] Amount,
    output logic [2:0] o,
    output logic [3:1] a,
    output logic       attempt,
    output logic       pin_locked,
    output logic       above_10k,
    output logic       transaction,
    output logic [3:0] b,
    output logic [3:0] new_balance
);

    // No handshakes: every input is a level sampled on each rising clk edge,
    // and every output except above_10k is a register updated on that edge.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PIN_CHECK = 3'd1,
        MODE      = 3'd2,
        VERIFY    = 3'd3,
        EXECUTE   = 3'd4,
        DONE      = 3'd5,
        LOCKED    = 3'd6
    } state_e;

    state_e     state_q;
    logic [3:1] a_q;
    logic       attempt_q;
    logic       pin_locked_q;
    logic       transaction_q;
    logic [3:0] b_q;
    logic [3:0] new_balance_q;

    logic [4:0] sum_full;
    logic [3:0] exec_result;
    logic       exec_commit;
    logic       card_removed;

    always_comb begin
        sum_full     = {1'b0, b_q} + {1'b0, Amount};
        exec_commit  = deposit_withdraw || (Amount <= b_q);
        exec_result  = b_q;
        if (deposit_withdraw) begin
            // Deposits saturate at the 4-bit ceiling rather than wrapping.
            exec_result = sum_full[4] ? 4'hF : sum_full[3:0];
        end else if (Amount <= b_q) begin
            exec_result = b_q - Amount;
        end
        card_removed = !insert_card && (state_q != IDLE) && (state_q != LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            a_q           <= 3'b000;
            attempt_q     <= 1'b0;
            pin_locked_q  <= 1'b0;
            transaction_q <= 1'b0;
            b_q           <= INIT_BALANCE;
            new_balance_q <= INIT_BALANCE;
        end else begin
            attempt_q     <= 1'b0;
            transaction_q <= 1'b0;
            if (card_removed) begin
                // Ejection aborts the session from any active state, including EXECUTE.
                state_q <= IDLE;
                a_q     <= 3'b000;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (insert_card) begin
                            state_q <= PIN_CHECK;
                        end
                    end
                    PIN_CHECK: begin
                        if (PIN) begin
                            state_q <= MODE;
                            a_q     <= 3'b000;
                        end else begin
                            attempt_q <= 1'b1;
                            a_q       <= {a_q[2:1], 1'b1};
                            // a[2] already set means this is the third failure.
                            if (a_q[2]) begin
                                state_q      <= LOCKED;
                                pin_locked_q <= 1'b1;
                            end
                        end
                    end
                    MODE: begin
                        if (!transac_mode) begin
                            state_q <= DONE;
                        end else if (above_10k) begin
                            state_q <= VERIFY;
                        end else begin
                            state_q <= EXECUTE;
                        end
                    end
                    VERIFY: begin
                        state_q <= face_recog ? EXECUTE : DONE;
                    end
                    EXECUTE: begin
                        state_q <= DONE;
                        if (exec_commit) begin
                            b_q           <= exec_result;
                            new_balance_q <= exec_result;
                            transaction_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    LOCKED: begin
`ifdef ATM_LOCK_CLEAR_ON_EJECT_EN
                        if (!insert_card) begin
                            state_q      <= IDLE;
                            a_q          <= 3'b000;
                            pin_locked_q <= 1'b0;
                        end
`else
                        state_q <= LOCKED;
`endif
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o           = state_q;
    assign a           = a_q;
    assign attempt     = attempt_q;
    assign pin_locked  = pin_locked_q;
    assign transaction = transaction_q;
    assign b           = b_q;
    assign new_balance = new_balance_q;
    assign above_10k   = (Amount > FACE_LIMIT);

endmodule

// File: tb/tb_atm_fsm_controller.sv
// Bench for atm_fsm_controller: directed session walk-throughs followed by random cycles
// checked against a session-level reference model.
module tb_atm_fsm_controller;

    localparam int INIT  = 10;
    localparam int LIMIT = 10;
    localparam int S_IDLE = 0, S_PIN = 1, S_MODE = 2, S_VERIFY = 3, S_EXEC = 4, S_DONE = 5, S_LOCKED = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       insert_card;
    logic       PIN;
    logic       transac_mode;
    logic       face_recog;
    logic       deposit_withdraw;
    logic [3:0] Amount;
    logic [2:0] o;
    logic [3:1] a;
    logic       attempt;
    logic       pin_locked;
    logic       above_10k;
    logic       transaction;
    logic [3:0] b;
    logic [3:0] new_balance;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: where the session is, how many wrong PINs so far, the balance.
    int m_state = S_IDLE;
    int m_fails = 0;
    int m_bal   = INIT;
    bit m_txn   = 1'b0;
    bit m_att   = 1'b0;

    atm_fsm_controller dut (
        .clk(clk), .reset(reset), .insert_card(insert_card), .PIN(PIN),
        .transac_mode(transac_mode), .face_recog(face_recog),
        .deposit_withdraw(deposit_withdraw), .Amount(Amount),
        .o(o), .a(a), .attempt(attempt), .pin_locked(pin_locked),
        .above_10k(above_10k), .transaction(transaction), .b(b), .new_balance(new_balance)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int amt;
        amt   = int'(Amount);
        m_att = 1'b0;
        m_txn = 1'b0;
        if (reset) begin
            m_state = S_IDLE;
            m_fails = 0;
            m_bal   = INIT;
        end else if (m_state == S_LOCKED) begin
`ifdef ATM_LOCK_CLEAR_ON_EJECT_EN
            if (!insert_card) begin
                m_state = S_IDLE;
                m_fails = 0;
            end
`endif
        end else if (m_state != S_IDLE && !insert_card) begin
            m_state = S_IDLE;
            m_fails = 0;
        end else begin
            case (m_state)
                S_IDLE:   if (insert_card) m_state = S_PIN;
                S_PIN: begin
                    if (PIN) begin
                        m_state = S_MODE;
                        m_fails = 0;
                    end else begin
                        m_fails++;
                        m_att = 1'b1;
                        if (m_fails == 3) m_state = S_LOCKED;
                    end
                end
                S_MODE:   m_state = !transac_mode ? S_DONE : (amt > LIMIT ? S_VERIFY : S_EXEC);
                S_VERIFY: m_state = face_recog ? S_EXEC : S_DONE;
                S_EXEC: begin
                    if (deposit_withdraw) begin
                        m_bal = (m_bal + amt > 15) ? 15 : m_bal + amt;
                        m_txn = 1'b1;
                    end else if (amt <= m_bal) begin
                        m_bal = m_bal - amt;
                        m_txn = 1'b1;
                    end
                    m_state = S_DONE;
                end
                default:  m_state = m_state;
            endcase
        end
    endtask

    // One clock: advance the model on the pre-edge inputs, then compare all outputs.
    task automatic tick(input string tag);
        logic [7:0] exp_a;
        model_step();
        @(posedge clk);
        #1;
        exp_a = 8'((1 << m_fails) - 1);
        chk({tag, ".o"}, 8'(o), 8'(m_state));
        chk({tag, ".a"}, 8'(a), exp_a);
        chk({tag, ".attempt"}, 8'(attempt), 8'(m_att));
        chk({tag, ".pin_locked"}, 8'(pin_locked), 8'(m_state == S_LOCKED));
        chk({tag, ".transaction"}, 8'(transaction), 8'(m_txn));
        chk({tag, ".b"}, 8'(b), 8'(m_bal));
        chk({tag, ".new_balance"}, 8'(new_balance), 8'(m_bal));
        chk({tag, ".above_10k"}, 8'(above_10k), 8'(int'(Amount) > LIMIT));
    endtask

    task automatic drive(input bit card, input bit pin, input bit mode, input bit face,
                         input bit dw, input int amt);
        insert_card      = card;
        PIN              = pin;
        transac_mode     = mode;
        face_recog       = face;
        deposit_withdraw = dw;
        Amount           = 4'(amt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick("reset");
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick("reset0");
        tick("reset1");
        reset = 1'b0;
        chk("reset_b_const", 8'(b), 8'd10);
        chk("reset_o_const", 8'(o), 8'd0);

        // Balance enquiry: 0 -> 1 -> 2 -> 5, then eject.
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick("enquiry");
        chk("enquiry_done", 8'(o), 8'd5);
        drive(0, 1, 0, 0, 0, 0);
        tick("enquiry_eject");

        // Deposit 2 -> 12, then deposit 5 saturates at 15.
        drive(1, 1, 1, 0, 1, 2);
        for (int i = 0; i < 5; i++) tick("dep2");
        chk("dep2_bal", 8'(b), 8'd12);
        drive(0, 1, 1, 0, 1, 2);
        tick("dep2_eject");
        drive(1, 1, 1, 0, 1, 5);
        for (int i = 0; i < 5; i++) tick("dep5");
        chk("dep5_sat", 8'(b), 8'd15);
        drive(0, 1, 1, 0, 1, 5);
        tick("dep5_eject");

        // Large withdrawal: face rejected, then face accepted but insufficient funds.
        do_reset();
        drive(1, 1, 1, 0, 0, 11);
        for (int i = 0; i < 4; i++) tick("wd11_noface");
        drive(0, 1, 1, 0, 0, 11);
        tick("wd11_eject");
        drive(1, 1, 1, 1, 0, 11);
        for (int i = 0; i < 6; i++) tick("wd11_face");
        chk("wd11_bal", 8'(b), 8'd10);
        drive(0, 1, 1, 1, 0, 11);
        tick("wd11_eject2");

        // Small withdrawal bypasses VERIFY.
        drive(1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) tick("wd1");
        chk("wd1_bal", 8'(b), 8'd9);
        drive(0, 1, 1, 0, 0, 1);
        tick("wd1_eject");

        // Amount 0 commits with no balance change.
        drive(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick("wd0");
        drive(0, 1, 1, 0, 0, 0);
        tick("wd0_eject");

        // Card removed in MODE and in VERIFY.
        drive(1, 1, 1, 0, 1, 12);
        tick("rm_mode_a");
        tick("rm_mode_b");
        drive(0, 1, 1, 0, 1, 12);
        tick("rm_mode");
        drive(1, 1, 1, 0, 1, 12);
        for (int i = 0; i < 3; i++) tick("rm_verify_a");
        drive(0, 1, 1, 0, 1, 12);
        tick("rm_verify");

        // One wrong PIN then a correct one clears the count.
        drive(1, 1, 0, 0, 0, 0);
        tick("pin_retry_in");
        PIN = 1'b0;
        tick("pin_retry_bad");
        PIN = 1'b1;
        tick("pin_retry_ok");
        drive(0, 1, 0, 0, 0, 0);
        tick("pin_retry_eject");

        // Three wrong PINs lock; ejection toggling, then reset.
        drive(1, 0, 0, 0, 0, 0);
        tick("lock_in");
        for (int i = 0; i < 3; i++) tick("lock_bad");
        chk("lock_state", 8'(o), 8'd6);
        drive(0, 0, 0, 0, 0, 0);
        tick("lock_eject");
        drive(1, 1, 0, 0, 0, 0);
        tick("lock_reinsert");
        do_reset();

        // Random cycles; locked sessions are eventually reset.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 15));
            reset = ($urandom_range(0, 199) == 0) ||
                    (m_state == S_LOCKED && $urandom_range(0, 7) == 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
